// File: rtl/qdec_pkg.sv
// Shared types and transition classifier for the A/B quadrature decoder.
// Optional glitch filter is enabled with QDEC_GLITCH_FILTER_EN.
package qdec_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } gray_e;

  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_UP   = 2'd1,
    T_DOWN = 2'd2,
    T_ILL  = 2'd3
  } trans_e;

  // Exactly one changed bit is either up or down; both changed is illegal.
  function automatic trans_e classify(
    input logic [1:0] p,
    input logic [1:0] c
  );
    trans_e t;
    t = T_NONE;
    if (p == c) begin
      t = T_NONE;
    end else if ((p ^ c) == 2'b11) begin
      t = T_ILL;
    end else begin
      unique case (p)
        S00: t = (c == S01) ? T_UP : T_DOWN;
        S01: t = (c == S11) ? T_UP : T_DOWN;
        S11: t = (c == S10) ? T_UP : T_DOWN;
        S10: t = (c == S00) ? T_UP : T_DOWN;
        default: t = T_NONE;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/qdec_sync_filt.sv
// One-bit synchroniser with an optional run-length glitch filter.
// Filter compiled in only when QDEC_GLITCH_FILTER_EN is defined.
module qdec_sync_filt
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef QDEC_GLITCH_FILTER_EN
  ,
  parameter int FILT_LEN = 3
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], d};
    end
  end

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);

  logic [CW-1:0] cnt;
  logic          f;

  // Follow the input only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      f   <= 1'b0;
    end else if (sr[SYNC_STAGES-1] != f) begin
      if (cnt == CW'(FILT_LEN - 1)) begin
        f   <= sr[SYNC_STAGES-1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign q = f;
`else
  assign q = sr[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: step pulse, direction and signed position.
// Define QDEC_GLITCH_FILTER_EN to add an input glitch filter.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    a_in,
  input  logic                    b_in,
  output logic                    step,
  output logic                    dir,
  output logic signed [CNT_W-1:0] pos,
  output logic                    err
);

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int PRIME_N = SYNC_STAGES + 1 + FILT_LEN;
`else
  localparam int PRIME_N = SYNC_STAGES + 1;
`endif
  // Sized to hold the longer priming window of either build.
  localparam int PW = $clog2(SYNC_STAGES + FILT_LEN + 2);

  logic          a_s;
  logic          b_s;
  logic [1:0]    cur;
  logic [1:0]    prev;
  logic [PW-1:0] prime_cnt;
  logic          primed;
  trans_e        tr;

  qdec_sync_filt #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_GLITCH_FILTER_EN
    ,
    .FILT_LEN(FILT_LEN)
`endif
  ) u_a (
    .clk(clk),
    .rst(rst),
    .d  (a_in),
    .q  (a_s)
  );

  qdec_sync_filt #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_GLITCH_FILTER_EN
    ,
    .FILT_LEN(FILT_LEN)
`endif
  ) u_b (
    .clk(clk),
    .rst(rst),
    .d  (b_in),
    .q  (b_s)
  );

  assign cur    = {a_s, b_s};
  assign primed = (prime_cnt == PW'(PRIME_N));
  assign tr     = classify(prev, cur);

  // Track prev every clock; decode only once the pipeline is primed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev      <= 2'b00;
      prime_cnt <= '0;
      step      <= 1'b0;
      dir       <= 1'b0;
      pos       <= '0;
      err       <= 1'b0;
    end else begin
      prev <= cur;
      step <= 1'b0;
      if (!primed) begin
        prime_cnt <= prime_cnt + 1'b1;
      end else if (en) begin
        unique case (1'b1)
          (tr == T_UP): begin
            step <= 1'b1;
            dir  <= 1'b1;
            pos  <= pos + 1'b1;
          end
          (tr == T_DOWN): begin
            step <= 1'b1;
            dir  <= 1'b0;
            pos  <= pos - 1'b1;
          end
          (tr == T_ILL): begin
            err <= 1'b1;
          end
          default: ;
        endcase
      end
      if (clr) begin
        pos <= '0;
        err <= 1'b0;
      end
    end
  end

endmodule
